// File: rtl/axi_chan_stream_arbiter.sv
// axi_chan_stream_arbiter
//   Shares one AXI4-Stream master port between N_CH packet sources (the
//   AR/AW/R/W/B snoop encoders). Grants are packet-atomic round-robin, the
//   winning source index is carried on m_tdest, chan_en gates new grants only,
//   and a beat watchdog forces tlast after MAX_BEATS beats (flagging err_trunc).
// Ports
//   aclk, aresetn        clock (rising edge) and async active-low reset
//   chan_en              per-channel grant enable
//   s_tvalid/s_tready/s_tdata/s_tlast   per-channel slave streams
//   m_tvalid/m_tready/m_tdata/m_tlast/m_tdest   shared master stream
//   err_trunc, err_clr   sticky truncation flag and its synchronous clear
module axi_chan_stream_arbiter #(
  parameter int N_CH      = 5,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 3,
  parameter int MAX_BEATS = 256
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [N_CH-1:0]          chan_en,
  input  logic [N_CH-1:0]          s_tvalid,
  output logic [N_CH-1:0]          s_tready,
  input  logic [N_CH*DATA_W-1:0]   s_tdata,
  input  logic [N_CH-1:0]          s_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tlast,
  output logic [ID_W-1:0]          m_tdest,
  output logic                     err_trunc,
  input  logic                     err_clr
);

  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic [N_CH-1:0]   eligible_s;
  logic              found_s;
  logic [ID_W-1:0]   pick_s;
  logic              sel_valid_s;
  logic              sel_last_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              busy_s;
  logic              forced_s;
  logic              beat_s;
  logic              trunc_s;

  assign eligible_s = s_tvalid & chan_en;
  assign busy_s     = (state_q == ST_BUSY);
  assign forced_s   = (cnt_q == CNT_LAST);

  // Round-robin pick: first eligible channel scanning from last_grant+1 with wrap.
  always_comb begin
    int idx;
    idx     = 0;
    found_s = 1'b0;
    pick_s  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last_q) + k) % N_CH;
      if (!found_s && eligible_s[idx]) begin
        found_s = 1'b1;
        pick_s  = ID_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Source mux driven from the registered grant.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_valid_s = s_tvalid[i];
        sel_last_s  = s_tlast[i];
        sel_data_s  = s_tdata[i*DATA_W +: DATA_W];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Only the granted source sees m_tready, and only while a packet is open.
  always_comb begin
    s_tready = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (busy_s && (grant_q == ID_W'(i))) begin
        s_tready[i] = m_tready;
      end else begin
        s_tready[i] = 1'b0;
      end
    end
  end

  // In IDLE the data/dest outputs keep the last value shown during BUSY.
  assign m_tvalid  = busy_s & sel_valid_s;
  assign m_tlast   = busy_s & (sel_last_s | forced_s);
  assign m_tdata   = busy_s ? sel_data_s : data_q;
  assign m_tdest   = grant_q;
  assign err_trunc = err_q;

  assign beat_s  = m_tvalid & m_tready;
  // The watchdog closed a packet whose source had not reached its own tlast.
  assign trunc_s = beat_s & forced_s & ~sel_last_s;

  // Next-state logic for the grant FSM, beat counter, held data and error flag.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d = ST_BUSY;
          grant_d = pick_s;
          last_d  = pick_s;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        data_d = sel_data_s;
        if (beat_s && m_tlast) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (beat_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A truncation in the same cycle as err_clr keeps the flag set.
    if (trunc_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State registers; channel 0 has first priority after reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(N_CH - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule
